msx_slot_initiator: RTL and testbench

MSX_SLOT_INITIATOR -- requirements
Module: msx_slot_initiator

---
 rtl/msx_slot_pkg.sv | 34 +++
 rtl/msx_slot_initiator_if.sv | 46 ++++
 rtl/msx_phase_timer.sv | 38 +++
 rtl/msx_slot_initiator.sv | 174 +++++++++++++++++
 tb/tb_msx_slot_initiator.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/msx_slot_pkg.sv
`default_nettype none
// ============================================================================
// Module      : msx_slot_pkg
// Description : Shared types and constants for the MSX cartridge-slot
//               initiator: bus-cycle state encoding, default phase lengths
//               and the phase-timer width.
// Revision    : 1.0 - initial release
// ============================================================================
package msx_slot_pkg;

  // Bus-cycle phases. Width is fixed at 2 bits so the encoding is explicit.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  // Default phase lengths in clock cycles (legal range 1..15 each).
  localparam int unsigned c_SETUP_CYC_DEF  = 1;
  localparam int unsigned c_STROBE_CYC_DEF = 3;
  localparam int unsigned c_HOLD_CYC_DEF   = 1;

  // Phase timer width; bounds every phase length to 15 cycles.
  localparam int unsigned c_TIMER_W = 4;

  // The timer flags done when it reaches zero, so a phase of N cycles
  // is timed by loading N-1 on entry.
  function automatic logic [c_TIMER_W-1:0] phase_load(input int unsigned cyc);
    phase_load = c_TIMER_W'(cyc - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/msx_slot_initiator_if.sv
`default_nettype none
// ============================================================================
// Module      : msx_slot_initiator_if
// Description : Host request/response handshake plus the MSX slot bus
//               (slot select, strobes, address, split data bus, wait).
//   master : the initiator view (drives ready/response and slot outputs)
//   slave  : the environment view (host requester + cartridge side)
//   Host side : req_valid, req_ready, req_write, req_addr[15:0],
//               req_wdata[7:0], rsp_valid, rsp_rdata[7:0]
//   Slot side : sltsl_n, rd_n, wr_n, a[15:0], d_out[7:0], d_oe,
//               d_in[7:0], wait_n
// Revision    : 1.0 - initial release
// ============================================================================
interface msx_slot_initiator_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;

  logic        sltsl_n;
  logic        rd_n;
  logic        wr_n;
  logic [15:0] a;
  logic [7:0]  d_out;
  logic        d_oe;
  logic [7:0]  d_in;
  logic        wait_n;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, d_in, wait_n,
    output req_ready, rsp_valid, rsp_rdata,
    output sltsl_n, rd_n, wr_n, a, d_out, d_oe
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, d_in, wait_n,
    input  req_ready, rsp_valid, rsp_rdata,
    input  sltsl_n, rd_n, wr_n, a, d_out, d_oe
  );

endinterface
`default_nettype wire

// File: rtl/msx_phase_timer.sv
`default_nettype none
// ============================================================================
// Module      : msx_phase_timer
// Description : 4-bit loadable down-counter with a done flag. Counts down to
//               zero and parks there; o_done is high while the count is zero.
//   clk     in  rising-edge clock
//   reset_n in  synchronous active-low reset (count cleared)
//   i_load  in  load i_value this edge (takes priority over counting)
//   i_value in  load value (phase length minus one)
//   o_done  out count is zero
// Revision    : 1.0 - initial release
// ============================================================================
module msx_phase_timer
  import msx_slot_pkg::*;
(
  input  wire logic                 clk,
  input  wire logic                 reset_n,
  input  wire logic                 i_load,
  input  wire logic [c_TIMER_W-1:0] i_value,
  output logic                      o_done
);

  logic [c_TIMER_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_done = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/msx_slot_initiator.sv
`default_nettype none
// ============================================================================
// Module      : msx_slot_initiator
// Description : Turns single host read/write requests into MSX cartridge-slot
//               bus cycles: SETUP (address + slot select), STROBE (rd_n or
//               wr_n low), HOLD (strobe released, one-cycle response pulse).
//   Parameters : SETUP_CYC, STROBE_CYC, HOLD_CYC  phase lengths, 1..15
//   clk        in  rising-edge clock
//   reset_n    in  synchronous active-low reset
//   bus        msx_slot_initiator_if.master  host handshake + slot bus
//   Build option : define MSX_SLOT_WAIT_EN to let wait_n stretch STROBE;
//                  otherwise wait_n is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module msx_slot_initiator
  import msx_slot_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = c_SETUP_CYC_DEF,
  parameter int unsigned STROBE_CYC = c_STROBE_CYC_DEF,
  parameter int unsigned HOLD_CYC   = c_HOLD_CYC_DEF
) (
  input  wire logic               clk,
  input  wire logic               reset_n,
  msx_slot_initiator_if.master    bus
);

  state_t               r_state;
  logic                 r_write;
  logic                 r_ready;
  logic                 r_sltsl_n;
  logic                 r_rd_n;
  logic                 r_wr_n;
  logic                 r_d_oe;
  logic [15:0]          r_a;
  logic [7:0]           r_d_out;
  logic                 r_rsp_valid;
  logic [7:0]           r_rsp_rdata;

  logic                 w_done;
  logic                 w_accept;
  logic                 w_wait_ok;
  logic                 w_strobe_exit;
  logic                 w_load;
  logic [c_TIMER_W-1:0] w_load_val;

  // req_ready is high exactly when the FSM is in IDLE.
  assign w_accept = (r_state == ST_IDLE) && bus.req_valid;

`ifdef MSX_SLOT_WAIT_EN
  // A low wait_n on the final strobe cycle holds STROBE for another cycle.
  assign w_wait_ok = bus.wait_n;
`else
  logic w_unused_wait;
  assign w_unused_wait = bus.wait_n;
  assign w_wait_ok     = 1'b1;
`endif

  assign w_strobe_exit = (r_state == ST_STROBE) && w_done && w_wait_ok;

  // Reload the phase timer on every state entry. HOLD->IDLE needs no load:
  // the count is already parked at zero for the next accept.
  always_comb begin
    w_load     = 1'b0;
    w_load_val = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_load     = 1'b1;
          w_load_val = phase_load(SETUP_CYC);
        end
      end
      ST_SETUP: begin
        if (w_done) begin
          w_load     = 1'b1;
          w_load_val = phase_load(STROBE_CYC);
        end
      end
      ST_STROBE: begin
        if (w_strobe_exit) begin
          w_load     = 1'b1;
          w_load_val = phase_load(HOLD_CYC);
        end
      end
      default: begin
      end
    endcase
  end

  msx_phase_timer u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .i_load  (w_load),
    .i_value (w_load_val),
    .o_done  (w_done)
  );

  // Bus-cycle FSM. All slot and host outputs are registered here and change
  // only on phase transitions, so they are glitch-free at the pins.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_write     <= 1'b0;
      r_ready     <= 1'b1;
      r_sltsl_n   <= 1'b1;
      r_rd_n      <= 1'b1;
      r_wr_n      <= 1'b1;
      r_d_oe      <= 1'b0;
      r_a         <= '0;
      r_d_out     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            // Capture the request; later changes on the request lines
            // have no effect on this cycle.
            r_state   <= ST_SETUP;
            r_write   <= bus.req_write;
            r_a       <= bus.req_addr;
            if (bus.req_write) begin
              r_d_out <= bus.req_wdata;
            end
            r_d_oe    <= bus.req_write;
            r_ready   <= 1'b0;
            r_sltsl_n <= 1'b0;
          end
        end
        ST_SETUP: begin
          if (w_done) begin
            r_state <= ST_STROBE;
            r_rd_n  <= r_write;
            r_wr_n  <= ~r_write;
          end
        end
        ST_STROBE: begin
          if (w_strobe_exit) begin
            r_state     <= ST_HOLD;
            r_rd_n      <= 1'b1;
            r_wr_n      <= 1'b1;
            r_sltsl_n   <= 1'b1;
            r_rsp_valid <= 1'b1;
            if (!r_write) begin
              r_rsp_rdata <= bus.d_in;
            end
          end
        end
        ST_HOLD: begin
          if (w_done) begin
            r_state <= ST_IDLE;
            r_d_oe  <= 1'b0;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = r_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.sltsl_n   = r_sltsl_n;
  assign bus.rd_n      = r_rd_n;
  assign bus.wr_n      = r_wr_n;
  assign bus.a         = r_a;
  assign bus.d_out     = r_d_out;
  assign bus.d_oe      = r_d_oe;

endmodule
`default_nettype wire

// File: tb/tb_msx_slot_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_msx_slot_initiator
// Description : Self-checking bench for msx_slot_initiator. A transaction
//               level model tracks, per accepted request, the cycle index
//               since accept and derives every slot/host output from the
//               phase-length rules. Directed cases cover the documented
//               read/write/back-to-back/reset/wait scenarios, then random
//               traffic with random wait_n, d_in and occasional resets.
//               Honours MSX_SLOT_WAIT_EN in its model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_msx_slot_initiator;

  localparam int S = 1;
  localparam int T = 3;
  localparam int H = 1;
`ifdef MSX_SLOT_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  msx_slot_initiator_if bus ();

  msx_slot_initiator #(
    .SETUP_CYC  (S),
    .STROBE_CYC (T),
    .HOLD_CYC   (H)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic        write;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } req_t;

  req_t rq[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit          m_known = 1'b0;
  bit          m_busy  = 1'b0;
  bit          m_acc   = 1'b0;
  bit          m_just_rst = 1'b0;
  int          m_k     = 0;   // cycle index since accept (1 = first SETUP cycle)
  int          m_send  = 0;   // index of the last strobe cycle
  logic        m_write = 1'b0;
  logic [15:0] m_addr  = '0;
  logic [15:0] m_a_last = '0;
  logic [7:0]  m_wdata = '0;
  logic [7:0]  m_rdata = '0;

  // Stimulus controls
  bit          din_fix_en = 1'b0;
  logic [7:0]  din_fix    = '0;
  int          wait_mode  = 0;  // 0: high, 1: random, 2: low at k=4,5
  bit          rst_req    = 1'b0;
  int          rst_at_k   = 0;

  // Measurements
  int cyc = 0;
  int acc_cyc = 0;
  int rsp_rel = -1;
  int ready_rel = -1;
  int rsp_cnt = 0;
  int acc_q[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Advance the model across a rising edge using the inputs held during
  // the cycle that is ending.
  task automatic model_edge();
    m_acc = 1'b0;
    if (!reset_n) begin
      m_known  = 1'b1;
      m_busy   = 1'b0;
      m_a_last = '0;
      m_rdata  = '0;
    end else if (m_known) begin
      if (!m_busy) begin
        if (bus.req_valid) begin
          m_acc    = 1'b1;
          m_busy   = 1'b1;
          m_k      = 1;
          m_send   = S + T;
          m_write  = bus.req_write;
          m_addr   = bus.req_addr;
          m_a_last = bus.req_addr;
          m_wdata  = bus.req_wdata;
        end
      end else begin
        if (m_k == m_send) begin
          if (WAIT_EN && !bus.wait_n) m_send++;
          else if (!m_write) m_rdata = bus.d_in;
        end
        if (m_k == m_send + H) m_busy = 1'b0;
        else m_k++;
      end
    end
  endtask

  task automatic model_check();
    bit strobe;
    if (!m_known) return;
    strobe = m_busy && (m_k > S) && (m_k <= m_send);
    check_val("req_ready", 32'(bus.req_ready), 32'(!m_busy));
    check_val("sltsl_n",   32'(bus.sltsl_n),   32'(!(m_busy && m_k <= m_send)));
    check_val("rd_n",      32'(bus.rd_n),      32'(!(strobe && !m_write)));
    check_val("wr_n",      32'(bus.wr_n),      32'(!(strobe && m_write)));
    check_val("rdwr_excl", 32'(bus.rd_n | bus.wr_n), 32'(1));
    check_val("d_oe",      32'(bus.d_oe),      32'(m_busy && m_write));
    if (m_busy && m_write) check_val("d_out", 32'(bus.d_out), 32'(m_wdata));
    if (m_just_rst) check_val("d_out_rst", 32'(bus.d_out), 32'(0));
    check_val("a",         32'(bus.a),         32'(m_busy ? m_addr : m_a_last));
    check_val("rsp_valid", 32'(bus.rsp_valid), 32'(m_busy && m_k == m_send + 1));
    check_val("rsp_rdata", 32'(bus.rsp_rdata), 32'(m_rdata));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    m_just_rst = !reset_n;
    cyc++;
    if (m_acc) begin
      acc_cyc   = cyc - 1;
      rsp_rel   = -1;
      ready_rel = -1;
      acc_q.push_back(acc_cyc);
      if (rq.size() > 0) void'(rq.pop_front());
    end
    #1;
    reset_n = !(rst_req || (rst_at_k != 0 && m_busy && m_k == rst_at_k));
    rst_req = 1'b0;
    if (rq.size() > 0) begin
      bus.req_valid = 1'b1;
      bus.req_write = rq[0].write;
      bus.req_addr  = rq[0].addr;
      bus.req_wdata = rq[0].wdata;
    end else begin
      bus.req_valid = 1'b0;
      bus.req_write = 1'($urandom);
      bus.req_addr  = 16'($urandom);
      bus.req_wdata = 8'($urandom);
    end
    bus.d_in = din_fix_en ? din_fix : 8'($urandom);
    case (wait_mode)
      0:       bus.wait_n = 1'b1;
      1:       bus.wait_n = ($urandom_range(0, 3) != 0);
      default: bus.wait_n = !(m_busy && (m_k == 4 || m_k == 5));
    endcase
    @(negedge clk);
    model_check();
    if (bus.rsp_valid === 1'b1) begin
      rsp_cnt++;
      if (rsp_rel < 0) rsp_rel = cyc - acc_cyc;
    end
    if (bus.req_ready === 1'b1 && ready_rel < 0) ready_rel = cyc - acc_cyc;
  endtask

  task automatic push_req(input logic w, input logic [15:0] ad, input logic [7:0] wd);
    req_t r;
    r.write = w;
    r.addr  = ad;
    r.wdata = wd;
    rq.push_back(r);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((rq.size() > 0 || m_busy) && n < 300) begin
      cycle();
      n++;
    end
    cycle();
    check_val("drain_timeout", 32'(n >= 300), 32'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap;
    reset_n       = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.d_in      = '0;
    bus.wait_n    = 1'b1;

    rst_req = 1'b1; cycle();
    rst_req = 1'b1; cycle();
    cycle();
    check_val("rst_ready", 32'(bus.req_ready), 32'(1));
    check_val("rst_a",     32'(bus.a),         32'(16'h0000));
    check_val("rst_rdata", 32'(bus.rsp_rdata), 32'(8'h00));

    // Read 0x6000 with d_in = 0x0A
    din_fix_en = 1'b1; din_fix = 8'h0A;
    push_req(1'b0, 16'h6000, 8'h00);
    drain();
    check_val("rd_lat_rsp",   32'(rsp_rel),       32'(S + T + 1));
    check_val("rd_lat_ready", 32'(ready_rel),     32'(S + T + H + 1));
    check_val("rd_data",      32'(bus.rsp_rdata), 32'(8'h0A));

    // Write 0x5000 / 0x08: read data must be left alone
    din_fix = 8'h55;
    push_req(1'b1, 16'h5000, 8'h08);
    drain();
    check_val("wr_lat_rsp",     32'(rsp_rel),       32'(S + T + 1));
    check_val("wr_keeps_rdata", 32'(bus.rsp_rdata), 32'(8'h0A));

    // Two queued reads: second accepted one full cycle period later
    acc_q.delete();
    push_req(1'b0, 16'h6000, 8'h00);
    push_req(1'b0, 16'h7000, 8'h00);
    drain();
    check_val("b2b_count", 32'(acc_q.size()), 32'(2));
    if (acc_q.size() == 2) check_val("b2b_gap", 32'(acc_q[1] - acc_q[0]), 32'(S + T + H + 1));

    // Reset in cycle 3 of a read aborts it with no response pulse
    rsp_cnt  = 0;
    rst_at_k = 3;
    push_req(1'b0, 16'h6123, 8'h00);
    drain();
    rst_at_k = 0;
    check_val("rst_no_rsp",   32'(rsp_cnt),       32'(0));
    check_val("rst_abort_a",  32'(bus.a),         32'(16'h0000));

    // wait_n low in cycles 4-5 of a read
    din_fix = 8'hC3;
    wait_mode = 2;
    push_req(1'b0, 16'h4321, 8'h00);
    drain();
    check_val("wait_lat_rsp", 32'(rsp_rel), 32'(S + T + 1 + (WAIT_EN ? 2 : 0)));
    check_val("wait_rdata",   32'(bus.rsp_rdata), 32'(8'hC3));

    // Random traffic
    din_fix_en = 1'b0;
    wait_mode  = 1;
    for (int i = 0; i < 250; i++) begin
      push_req(1'($urandom), 16'($urandom), 8'($urandom));
      if ($urandom_range(0, 3) == 0) push_req(1'($urandom), 16'($urandom), 8'($urandom));
      gap = $urandom_range(0, 8);
      repeat (gap) begin
        if ($urandom_range(0, 199) == 0) rst_req = 1'b1;
        cycle();
      end
      drain();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
